// File: rtl/matrix_pkg.sv
// Shared types and default geometry for the matrix frame read-side sequencer.
package matrix_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      PRESENT,
      DONE
   } reader_state_t;

   // Default build: 6 banks x 2 blocks of 2250 one-byte addresses.
   localparam int LANES    = 12;
   localparam int ADDR_MAX = 2249;

   function automatic logic [7:0] lane_byte(input logic [LANES*8-1:0] flat, input int i);
      return flat[i*8 +: 8];
   endfunction

endpackage

// File: rtl/matrix_frame_reader.sv
// Sweeps every address of the stable buffer half after each buffer-updated pulse
// and hands the lane bytes of each address to the transmitters one word at a time.
module matrix_frame_reader
   import matrix_pkg::*;
#(
   parameter int BYTES_PER_BLOCK = 2250,
   parameter int BANK_COUNT      = 6,
   parameter int BLOCK_COUNT     = 2,
   parameter int DATA_WIDTH      = 8,
   parameter int READ_LATENCY    = 2,
   localparam int LANE_COUNT     = BANK_COUNT * BLOCK_COUNT,
   localparam int WORDS          = BYTES_PER_BLOCK * 8 / DATA_WIDTH,
   localparam int ADDR_W         = $clog2(WORDS)
) (
   input  logic                             I_clk,
   input  logic                             I_rst_n,
   input  logic                             I_frame_trigger,
   input  logic                             I_buffer_valid,
   output logic                             O_read_enable,
   output logic [ADDR_W-1:0]                O_read_address,
   input  logic [LANE_COUNT*DATA_WIDTH-1:0] I_read_data_flat,
   output logic [LANE_COUNT*DATA_WIDTH-1:0] O_lane_data_flat,
   output logic                             O_valid,
   input  logic                             I_ready,
   output logic                             O_first,
   output logic                             O_last,
   output logic                             O_busy,
   output logic                             O_frame_done,
   output reader_state_t                    O_state
);

   localparam int ADDR_LAST = WORDS - 1;
   localparam int LAT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   reader_state_t     state;
   logic [ADDR_W-1:0] addr;
   logic [LAT_W-1:0]  lat_cnt;
   logic              pending;

   assign O_read_address = addr;
   assign O_state        = state;

   // Handshake: a word transfers on a clock where O_valid && I_ready; O_valid,
   // data, O_first and O_last hold unchanged until then, and I_ready is ignored
   // while O_valid is low.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state            <= IDLE;
         addr             <= '0;
         lat_cnt          <= '0;
         pending          <= 1'b0;
         O_read_enable    <= 1'b0;
         O_lane_data_flat <= '0;
         O_valid          <= 1'b0;
         O_first          <= 1'b0;
         O_last           <= 1'b0;
         O_busy           <= 1'b0;
         O_frame_done     <= 1'b0;
      end else begin
         O_read_enable <= 1'b0;
         O_frame_done  <= 1'b0;
         // Triggers during a sweep coalesce into a single deferred sweep.
         if (I_frame_trigger && state != IDLE) pending <= 1'b1;
         case (state)
            IDLE: begin
               if (I_frame_trigger || pending) begin
                  pending <= 1'b0;
                  if (I_buffer_valid) begin
                     state         <= ISSUE;
                     addr          <= '0;
                     O_read_enable <= 1'b1;
                     O_busy        <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               state   <= WAIT;
               lat_cnt <= '0;
            end
            WAIT: begin
               // The last WAIT clock is the one where the buffer output is valid.
               if (lat_cnt == LAT_W'(READ_LATENCY - 1)) begin
                  O_lane_data_flat <= I_read_data_flat;
                  O_valid          <= 1'b1;
                  O_first          <= (addr == '0);
                  O_last           <= (addr == ADDR_W'(ADDR_LAST));
                  state            <= PRESENT;
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end
            PRESENT: begin
               if (I_ready) begin
                  O_valid <= 1'b0;
                  O_first <= 1'b0;
                  O_last  <= 1'b0;
                  if (addr == ADDR_W'(ADDR_LAST)) begin
                     state        <= DONE;
                     O_frame_done <= 1'b1;
                  end else begin
                     addr          <= addr + 1'b1;
                     state         <= ISSUE;
                     O_read_enable <= 1'b1;
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               O_busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
